// File: rtl/ctrl_stall_scoreboard.sv
// Hazard-stall controller for the 5-stage pipeline: tracks E/M producer timing and the
// mult/div busy window, freezing F/D and bubbling D->E when a source cannot be forwarded.
module ctrl_stall_scoreboard #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] Tuse_rs,
   input  logic [1:0] Tuse_rt,
   input  logic [4:0] SPL_rs,
   input  logic [4:0] SPL_rt,
   input  logic       GRFWE_D,
   input  logic [4:0] GRF_A3_D,
   input  logic [1:0] Tnew_D,
   input  logic       MD_start_D,
   input  logic       MD_div_D,
   input  logic       MD_use_D,
   output logic       Stall,
   output logic       Flush_E,
   output logic       MD_busy,
   output logic [1:0] Tnew_E,
   output logic [1:0] Tnew_M
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   function automatic logic [1:0] sat_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

   logic             e_we_q, e_we_d;
   logic [4:0]       e_a3_q, e_a3_d;
   logic [1:0]       e_tnew_q, e_tnew_d;
   logic             e_md_start_q, e_md_start_d;
   logic             e_md_div_q, e_md_div_d;
   logic             m_we_q, m_we_d;
   logic [4:0]       m_a3_q, m_a3_d;
   logic [1:0]       m_tnew_q, m_tnew_d;
   logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

   logic e_hit_rs, e_hit_rt, m_hit_rs, m_hit_rt;
   logic stall_e_rs, stall_e_rt, stall_m_rs, stall_m_rt;
   logic md_busy;
   logic stall;

   // The E slot holds the youngest producer, so a match there hides any older M match.
   always_comb begin
      e_hit_rs   = (SPL_rs != 5'd0) && e_we_q && (SPL_rs == e_a3_q);
      e_hit_rt   = (SPL_rt != 5'd0) && e_we_q && (SPL_rt == e_a3_q);
      m_hit_rs   = (SPL_rs != 5'd0) && m_we_q && (SPL_rs == m_a3_q) && !e_hit_rs;
      m_hit_rt   = (SPL_rt != 5'd0) && m_we_q && (SPL_rt == m_a3_q) && !e_hit_rt;
      stall_e_rs = e_hit_rs && (e_tnew_q > Tuse_rs);
      stall_e_rt = e_hit_rt && (e_tnew_q > Tuse_rt);
      stall_m_rs = m_hit_rs && (m_tnew_q > Tuse_rs);
      stall_m_rt = m_hit_rt && (m_tnew_q > Tuse_rt);
      md_busy    = (md_cnt_q != '0) || e_md_start_q;
      stall      = stall_e_rs || stall_e_rt || stall_m_rs || stall_m_rt ||
                   (MD_use_D && md_busy);
   end

   always_comb begin
      m_we_d       = e_we_q;
      m_a3_d       = e_a3_q;
      m_tnew_d     = sat_dec(e_tnew_q);
      e_we_d       = 1'b0;
      e_a3_d       = 5'd0;
      e_tnew_d     = 2'd0;
      e_md_start_d = 1'b0;
      e_md_div_d   = 1'b0;
      md_cnt_d     = md_cnt_q;
      if (!stall) begin
         e_we_d       = GRFWE_D;
         e_a3_d       = GRF_A3_D;
         e_tnew_d     = Tnew_D;
         e_md_start_d = MD_start_D;
         e_md_div_d   = MD_div_D;
      end
      // The counter is loaded only once the operation has actually left E.
      if (e_md_start_q) begin
         md_cnt_d = e_md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (md_cnt_q != '0) begin
         md_cnt_d = md_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_we_q       <= 1'b0;
         e_a3_q       <= 5'd0;
         e_tnew_q     <= 2'd0;
         e_md_start_q <= 1'b0;
         e_md_div_q   <= 1'b0;
         m_we_q       <= 1'b0;
         m_a3_q       <= 5'd0;
         m_tnew_q     <= 2'd0;
         md_cnt_q     <= '0;
      end else begin
         e_we_q       <= e_we_d;
         e_a3_q       <= e_a3_d;
         e_tnew_q     <= e_tnew_d;
         e_md_start_q <= e_md_start_d;
         e_md_div_q   <= e_md_div_d;
         m_we_q       <= m_we_d;
         m_a3_q       <= m_a3_d;
         m_tnew_q     <= m_tnew_d;
         md_cnt_q     <= md_cnt_d;
      end
   end

   assign Stall   = stall;
   assign Flush_E = stall;
   assign MD_busy = md_busy;
   assign Tnew_E  = e_tnew_q;
   assign Tnew_M  = m_tnew_q;

endmodule

// File: tb/tb_ctrl_stall_scoreboard.sv
// Bench for ctrl_stall_scoreboard: each driven D-stage cycle queues its expected outputs,
// which are popped and compared on the following falling edge.
module tb_ctrl_stall_scoreboard;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] Tuse_rs, Tuse_rt, Tnew_D;
   logic [4:0] SPL_rs, SPL_rt, GRF_A3_D;
   logic       GRFWE_D, MD_start_D, MD_div_D, MD_use_D;
   logic       Stall, Flush_E, MD_busy;
   logic [1:0] Tnew_E, Tnew_M;

   typedef struct {
      logic       stall;
      logic       busy;
      logic [1:0] te;
      logic [1:0] tm;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   ctrl_stall_scoreboard #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset),
      .Tuse_rs(Tuse_rs), .Tuse_rt(Tuse_rt), .SPL_rs(SPL_rs), .SPL_rt(SPL_rt),
      .GRFWE_D(GRFWE_D), .GRF_A3_D(GRF_A3_D), .Tnew_D(Tnew_D),
      .MD_start_D(MD_start_D), .MD_div_D(MD_div_D), .MD_use_D(MD_use_D),
      .Stall(Stall), .Flush_E(Flush_E), .MD_busy(MD_busy),
      .Tnew_E(Tnew_E), .Tnew_M(Tnew_M)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk({e.tag, ".stall"},   32'(Stall),   32'(e.stall));
         chk({e.tag, ".flush"},   32'(Flush_E), 32'(e.stall));
         chk({e.tag, ".md_busy"}, 32'(MD_busy), 32'(e.busy));
         chk({e.tag, ".tnew_e"},  32'(Tnew_E),  32'(e.te));
         chk({e.tag, ".tnew_m"},  32'(Tnew_M),  32'(e.tm));
      end
   end

   // One D-stage cycle: present the instruction, queue what the outputs must be, advance.
   task automatic cyc(input logic [4:0] rs, input logic [1:0] urs,
                      input logic [4:0] rt, input logic [1:0] urt,
                      input logic we, input logic [4:0] a3, input logic [1:0] tn,
                      input logic mds, input logic mdd, input logic mdu,
                      input logic est, input logic ebusy,
                      input logic [1:0] ete, input logic [1:0] etm, input string tag);
      exp_t e;
      SPL_rs = rs; Tuse_rs = urs; SPL_rt = rt; Tuse_rt = urt;
      GRFWE_D = we; GRF_A3_D = a3; Tnew_D = tn;
      MD_start_D = mds; MD_div_D = mdd; MD_use_D = mdu;
      e.stall = est; e.busy = ebusy; e.te = ete; e.tm = etm; e.tag = tag;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic nop(input logic ebusy, input logic [1:0] ete, input logic [1:0] etm,
                      input string tag);
      cyc(5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0,
          1'b0, ebusy, ete, etm, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b1;
      SPL_rs = 5'd0; Tuse_rs = 2'd3; SPL_rt = 5'd0; Tuse_rt = 2'd3;
      GRFWE_D = 1'b0; GRF_A3_D = 5'd0; Tnew_D = 2'd0;
      MD_start_D = 1'b0; MD_div_D = 1'b0; MD_use_D = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      nop(0, 0, 0, "reset_state");

      // load-use: one stall
      cyc(0, 3, 0, 3, 1, 8, 2, 0, 0, 0, 0, 0, 0, 0, "lu_lw");
      cyc(8, 1, 0, 3, 1, 10, 1, 0, 0, 0, 1, 0, 2, 0, "lu_add_stall");
      cyc(8, 1, 0, 3, 1, 10, 1, 0, 0, 0, 0, 0, 0, 1, "lu_add_go");
      nop(0, 1, 0, "lu_d1");
      nop(0, 0, 0, "lu_d2");

      // load-branch: two stalls
      cyc(0, 3, 0, 3, 1, 9, 2, 0, 0, 0, 0, 0, 0, 0, "lb_lw");
      cyc(9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, "lb_beq_s1");
      cyc(9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "lb_beq_s2");
      cyc(9, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "lb_beq_go");
      nop(0, 0, 0, "lb_d1");

      // register 0 and unread sources never stall
      cyc(0, 3, 0, 3, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, "z_lw0");
      cyc(0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, "z_add_r0");
      nop(0, 0, 1, "z_d1");
      cyc(0, 3, 0, 3, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, "z_lw5");
      cyc(0, 3, 5, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, "z_rt_unused");
      nop(0, 0, 1, "z_d2");
      nop(0, 0, 0, "z_d3");

      // ALU to store (no stall), ALU to branch (one stall)
      cyc(0, 3, 0, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, "as_add");
      cyc(4, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "as_sw");
      nop(0, 0, 0, "as_d1");
      cyc(0, 3, 0, 3, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, "ab_add");
      cyc(4, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "ab_beq_stall");
      cyc(4, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "ab_beq_go");
      nop(0, 0, 0, "ab_d1");

      // rs and rt both hazard on the same load: still a single stall cycle
      cyc(0, 3, 0, 3, 1, 7, 2, 0, 0, 0, 0, 0, 0, 0, "rr_lw");
      cyc(7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, "rr_stall");
      cyc(7, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "rr_go");
      nop(0, 0, 0, "rr_d1");

      // younger E producer (jal, Tnew 0) masks older M load on the same register
      cyc(0, 3, 0, 3, 1, 31, 2, 0, 0, 0, 0, 0, 0, 0, "mk_lw31");
      cyc(0, 3, 0, 3, 1, 31, 0, 0, 0, 0, 0, 0, 2, 0, "mk_jal");
      cyc(31, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "mk_beq");
      nop(0, 0, 0, "mk_d1");

      // mult then mflo: stall t+1..t+6, issue t+7
      cyc(0, 3, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "mul_issue");
      for (int i = 0; i < 6; i++)
         cyc(0, 3, 0, 3, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, "mul_mflo_wait");
      cyc(0, 3, 0, 3, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, "mul_mflo_go");
      nop(0, 1, 0, "mul_d1");
      nop(0, 0, 0, "mul_d2");

      // div then a mult that must wait and load its own count only once issued
      cyc(0, 3, 0, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, "div_issue");
      for (int i = 0; i < 11; i++)
         cyc(0, 3, 0, 3, 0, 0, 0, 1, 0, 1, 1, 1, 0, 0, "div_mult_wait");
      cyc(0, 3, 0, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, "div_mult_go");
      for (int i = 0; i < 6; i++)
         nop(1, 0, 0, "mult2_busy");
      nop(0, 0, 0, "mult2_done");

      // reset during a div stall (md_cnt at 7)
      cyc(0, 3, 0, 3, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, "rst_div");
      for (int i = 0; i < 4; i++)
         cyc(0, 3, 0, 3, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, "rst_mflo_wait");
      reset = 1'b1;
      cyc(0, 3, 0, 3, 1, 2, 1, 0, 0, 1, 1, 1, 0, 0, "rst_asserted");
      reset = 1'b0;
      cyc(0, 3, 0, 3, 1, 2, 1, 0, 0, 1, 0, 0, 0, 0, "rst_cleared");
      nop(0, 1, 0, "rst_d1");

      // reset with a load in flight clears both slots
      cyc(0, 3, 0, 3, 1, 3, 2, 0, 0, 0, 0, 0, 0, 0, "rst2_lw");
      reset = 1'b1;
      nop(0, 2, 0, "rst2_asserted");
      reset = 1'b0;
      nop(0, 0, 0, "rst2_cleared");

      @(negedge clk);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
